// File: rtl/power_pack_array_pkg.sv
// Shared types and helpers for the power-up box array: slot state encoding,
// LFSR geometry, counter width and the on-screen position fold.
package power_pack_array_pkg;

  typedef enum logic [1:0] {
    SLOT_IDLE   = 2'd0,
    SLOT_ACTIVE = 2'd1,
    SLOT_COOL   = 2'd2
  } slot_state_t;

  localparam int LFSR_W     = 20;
  localparam int LFSR_TAP_A = 19;  // x^20 term
  localparam int LFSR_TAP_B = 16;  // x^17 term
  localparam int CNT_W      = 12;

  // One Fibonacci step: shift left, feed back XOR of the two tap bits.
  function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] cur);
    return {cur[LFSR_W-2:0], cur[LFSR_TAP_A] ^ cur[LFSR_TAP_B]};
  endfunction

  // Fold a raw 10-bit coordinate into [0, lim) with a single subtraction;
  // valid because lim is at least half of the 10-bit range.
  function automatic logic [10:0] fold_pos(input logic [10:0] raw, input logic [10:0] lim);
    logic [10:0] res;
    if (raw >= lim) begin
      res = raw - lim;
    end else begin
      res = raw;
    end
    return res;
  endfunction

endpackage

// File: rtl/power_pack_array_lfsr.sv
// Free-running 20-bit Fibonacci LFSR supplying spawn positions.
// An all-zero seed would lock up, so it is replaced by 1.
module power_pack_array_lfsr
  import power_pack_array_pkg::*;
#(
  parameter logic [LFSR_W-1:0] SEED = 20'hACE1
) (
  input  logic              clk,
  input  logic              reset,
  output logic [LFSR_W-1:0] rnd
);

  localparam logic [LFSR_W-1:0] SEED_EFF = (SEED == 20'd0) ? 20'd1 : SEED;

  // Load the seed on reset, otherwise advance every clock.
  always_ff @(posedge clk) begin
    if (reset) begin
      rnd <= SEED_EFF;
    end else begin
      rnd <= lfsr_next(rnd);
    end
  end

endmodule

// File: rtl/power_pack_array.sv
// Array of power-up box slots for the Pong playfield. Each slot cycles
// IDLE -> ACTIVE -> COOL -> IDLE; spawns go to the lowest IDLE slot at an
// LFSR-derived position, and visible boxes are merged into one pixel output.
module power_pack_array
  import power_pack_array_pkg::*;
#(
  parameter int          NUM_PACKS = 4,
  parameter int          WIDTH     = 20,
  parameter int          HEIGHT    = 20,
  parameter logic [7:0]  COLOR     = 8'b000_000_11,
  parameter int          H_MAX     = 1024,
  parameter int          V_MAX     = 768,
  parameter int          LIFETIME  = 600,
  parameter int          BLINK     = 120,
  parameter int          COOLDOWN  = 60,
  parameter logic [19:0] SEED      = 20'hACE1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      frame_tick,
  input  logic                      spawn,
  input  logic [NUM_PACKS-1:0]      eaten,
  input  logic [10:0]               hcount,
  input  logic [9:0]                vcount,
  output logic [NUM_PACKS-1:0]      active,
  output logic [11*NUM_PACKS-1:0]   rx_flat,
  output logic [10*NUM_PACKS-1:0]   ry_flat,
  output logic                      spawn_drop,
  output logic [NUM_PACKS-1:0]      expired,
  output logic [7:0]                r2pixel
);

  localparam logic [10:0]      H_LIM     = 11'(H_MAX - WIDTH);
  localparam logic [10:0]      V_LIM     = 11'(V_MAX - HEIGHT);
  localparam logic [CNT_W-1:0] LIFE_INIT = CNT_W'(LIFETIME);
  localparam logic [CNT_W-1:0] COOL_INIT = CNT_W'(COOLDOWN);
  localparam logic [CNT_W-1:0] BLINK_TH  = CNT_W'(BLINK);
  localparam logic [11:0]      W_EXT     = 12'(WIDTH);
  localparam logic [10:0]      H_EXT     = 11'(HEIGHT);

  logic [LFSR_W-1:0]    rnd_s;
  logic [10:0]          spawn_rx_s;
  logic [9:0]           spawn_ry_s;
  logic [NUM_PACKS-1:0] slot_idle_s;
  logic [NUM_PACKS-1:0] grant_s;
  logic                 any_idle_s;
  logic [NUM_PACKS-1:0] hit_s;
  logic [2:0]           frame_cnt_r;
  logic                 blink_phase_s;

  power_pack_array_lfsr #(.SEED(SEED)) u_lfsr (
    .clk   (clk),
    .reset (reset),
    .rnd   (rnd_s)
  );

  assign spawn_rx_s    = fold_pos({1'b0, rnd_s[9:0]}, H_LIM);
  assign spawn_ry_s    = 10'(fold_pos({1'b0, rnd_s[19:10]}, V_LIM));
  assign blink_phase_s = frame_cnt_r[2];

  // Lowest-index IDLE slot wins the spawn; any_idle_s flags that one exists.
  always_comb begin
    grant_s    = {NUM_PACKS{1'b0}};
    any_idle_s = 1'b0;
    for (int i = 0; i < NUM_PACKS; i++) begin
      if (slot_idle_s[i] && !any_idle_s) begin
        grant_s[i] = 1'b1;
        any_idle_s = 1'b1;
      end else begin
        grant_s[i] = 1'b0;
      end
    end
  end

  for (genvar gi = 0; gi < NUM_PACKS; gi++) begin : g_slot
    slot_state_t      state_r;
    logic [CNT_W-1:0] life_r;
    logic [CNT_W-1:0] cnt_r;
    logic [10:0]      rx_r;
    logic [9:0]       ry_r;
    logic             active_r;
    logic             expired_r;
    logic             visible_s;

    // Slot lifecycle: spawn, frame-based lifetime or eat, cooldown, back to idle.
    always_ff @(posedge clk) begin
      if (reset) begin
        state_r   <= SLOT_IDLE;
        life_r    <= {CNT_W{1'b0}};
        cnt_r     <= {CNT_W{1'b0}};
        rx_r      <= 11'd0;
        ry_r      <= 10'd0;
        active_r  <= 1'b0;
        expired_r <= 1'b0;
      end else begin
        expired_r <= 1'b0;
        case (state_r)
          SLOT_IDLE: begin
            if (spawn && grant_s[gi]) begin
              state_r  <= SLOT_ACTIVE;
              active_r <= 1'b1;
              life_r   <= LIFE_INIT;
              rx_r     <= spawn_rx_s;
              ry_r     <= spawn_ry_s;
            end
          end
          SLOT_ACTIVE: begin
            if (eaten[gi]) begin
              // Eat beats a coincident expiry: no expired pulse.
              state_r  <= SLOT_COOL;
              active_r <= 1'b0;
              cnt_r    <= COOL_INIT;
              rx_r     <= 11'd0;
              ry_r     <= 10'd0;
            end else if (frame_tick) begin
              life_r <= life_r - 12'd1;
              if (life_r == 12'd1) begin
                state_r   <= SLOT_COOL;
                active_r  <= 1'b0;
                cnt_r     <= COOL_INIT;
                expired_r <= 1'b1;
              end
            end
          end
          SLOT_COOL: begin
            if (frame_tick) begin
              if (cnt_r == 12'd1) begin
                state_r <= SLOT_IDLE;
              end else begin
                cnt_r <= cnt_r - 12'd1;
              end
            end
          end
          default: begin
            state_r  <= SLOT_IDLE;
            active_r <= 1'b0;
          end
        endcase
      end
    end

    assign slot_idle_s[gi] = (state_r == SLOT_IDLE);
    assign visible_s       = active_r && ((life_r > BLINK_TH) || blink_phase_s);
    // Extended-width compares so rx+WIDTH / ry+HEIGHT never wrap.
    assign hit_s[gi] = visible_s
                    && ({1'b0, hcount} >= {1'b0, rx_r})
                    && ({1'b0, hcount} <  ({1'b0, rx_r} + W_EXT))
                    && ({1'b0, vcount} >= {1'b0, ry_r})
                    && ({1'b0, vcount} <  ({1'b0, ry_r} + H_EXT));

    assign active[gi]             = active_r;
    assign expired[gi]            = expired_r;
    assign rx_flat[11*gi +: 11]   = rx_r;
    assign ry_flat[10*gi +: 10]   = ry_r;
  end

  // Shared frame counter whose MSB drives the blink phase.
  always_ff @(posedge clk) begin
    if (reset) begin
      frame_cnt_r <= 3'd0;
    end else if (frame_tick) begin
      frame_cnt_r <= frame_cnt_r + 3'd1;
    end
  end

  // Flag a spawn request that found no IDLE slot.
  always_ff @(posedge clk) begin
    if (reset) begin
      spawn_drop <= 1'b0;
    end else begin
      spawn_drop <= spawn && !any_idle_s;
    end
  end

  // Registered pixel: colour when any visible box covers the current pixel.
  always_ff @(posedge clk) begin
    if (reset) begin
      r2pixel <= 8'd0;
    end else begin
      r2pixel <= (|hit_s) ? COLOR : 8'd0;
    end
  end

endmodule
